// File: rtl/min3_triple_loader.sv
// min3_triple_loader
//   Groups a serial byte stream into triples and presents each triple as held,
//   registered a/b/c operands for a free-running three-input minimum stage.
//   trip_valid pulses in the first cycle a new triple is visible; min_valid is
//   the same pulse delayed by LAT cycles so it lines up with the min stage's d.
//
// Optional feature (macro MIN3_LOADER_PAD_EN):
//   defined   - flush in S1/S2 publishes the partial triple, padding missing
//               slots with all-ones (neutral for min).
//   undefined - flush discards the staged bytes without publishing.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_data    in   stream byte (DW)
//   in_valid   in   in_data valid this cycle
//   in_ready   out  loader can accept (= !flush)
//   flush      in   synchronous abort/close of the partial triple
//   a, b, c    out  registered operands 0/1/2 (DW)
//   trip_valid out  one-cycle pulse: a/b/c show a new triple
//   min_valid  out  one-cycle pulse, LAT cycles after trip_valid
//   fill       out  bytes currently staged (0..2)
//   trip_cnt   out  saturating count of published triples (CNT_W)

module min3_triple_loader #(
    parameter int unsigned DW    = 8,
    parameter int unsigned LAT   = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DW-1:0]    in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [DW-1:0]    a,
    output logic [DW-1:0]    b,
    output logic [DW-1:0]    c,
    output logic             trip_valid,
    output logic             min_valid,
    output logic [1:0]       fill,
    output logic [CNT_W-1:0] trip_cnt
);

    localparam logic [1:0] S0 = 2'd0;
    localparam logic [1:0] S1 = 2'd1;
    localparam logic [1:0] S2 = 2'd2;

    logic [1:0]       r_state;
    logic [DW-1:0]    r_sa;
    logic [DW-1:0]    r_sb;
    logic [DW-1:0]    r_a;
    logic [DW-1:0]    r_b;
    logic [DW-1:0]    r_c;
    logic             r_trip_valid;
    logic [LAT-1:0]   r_pipe;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_publish;
    logic [DW-1:0]    w_a_nxt;
    logic [DW-1:0]    w_b_nxt;
    logic [DW-1:0]    w_c_nxt;

    // The min stage samples every cycle, so flush is the only backpressure.
    assign in_ready = !flush;
    assign w_accept = in_valid && !flush;

    always_comb begin
        w_publish = 1'b0;
        w_a_nxt   = r_sa;
        w_b_nxt   = r_sb;
        w_c_nxt   = in_data;
        if (w_accept && (r_state == S2)) begin
            w_publish = 1'b1;
        end
`ifdef MIN3_LOADER_PAD_EN
        else if (flush && (r_state == S1)) begin
            w_publish = 1'b1;
            w_b_nxt   = {DW{1'b1}};
            w_c_nxt   = {DW{1'b1}};
        end else if (flush && (r_state == S2)) begin
            w_publish = 1'b1;
            w_c_nxt   = {DW{1'b1}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S0;
            r_sa         <= '0;
            r_sb         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_c          <= '0;
            r_trip_valid <= 1'b0;
            r_pipe       <= '0;
            r_cnt        <= '0;
        end else begin
            r_trip_valid <= w_publish;

            // Delay line aligning min_valid with the downstream registered d.
            r_pipe[0] <= r_trip_valid;
            for (int i = 1; i < LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end

            if (w_publish) begin
                r_a <= w_a_nxt;
                r_b <= w_b_nxt;
                r_c <= w_c_nxt;
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end

            if (flush) begin
                r_state <= S0;
            end else if (w_accept) begin
                case (r_state)
                    S0: begin
                        r_sa    <= in_data;
                        r_state <= S1;
                    end
                    S1: begin
                        r_sb    <= in_data;
                        r_state <= S2;
                    end
                    default: r_state <= S0;
                endcase
            end
        end
    end

    assign a          = r_a;
    assign b          = r_b;
    assign c          = r_c;
    assign trip_valid = r_trip_valid;
    assign min_valid  = r_pipe[LAT-1];
    assign fill       = r_state;
    assign trip_cnt   = r_cnt;

endmodule

// File: tb/tb_min3_triple_loader.sv
// Bench for min3_triple_loader: table-driven triples plus hand-written flush and
// reset sequences. Expected triples are queued when stimulus is driven and
// popped when trip_valid appears; expected minima are then queued with the
// cycle on which min_valid and the modelled downstream d must show them.

module tb_min3_triple_loader;

    localparam int LAT = 2;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        flush;
    logic        in_ready;
    logic [7:0]  a, b, c;
    logic        trip_valid, min_valid;
    logic [1:0]  fill;
    logic [15:0] trip_cnt;

    logic        s_in_ready;
    logic [7:0]  s_a, s_b, s_c;
    logic        s_trip_valid, s_min_valid;
    logic [1:0]  s_fill;
    logic [1:0]  s_trip_cnt;

    min3_triple_loader #(.DW(8), .LAT(LAT), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .a(a), .b(b), .c(c),
        .trip_valid(trip_valid), .min_valid(min_valid), .fill(fill), .trip_cnt(trip_cnt)
    );

    // Narrow-counter instance, driven in lockstep, for saturation.
    min3_triple_loader #(.DW(8), .LAT(LAT), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(s_in_ready), .flush(flush), .a(s_a), .b(s_b), .c(s_c),
        .trip_valid(s_trip_valid), .min_valid(s_min_valid), .fill(s_fill),
        .trip_cnt(s_trip_cnt)
    );

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] z;
        logic [7:0] m;
    } vec_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
    } trip_t;

    typedef struct {
        logic [7:0] m;
        int         due;
    } min_t;

    trip_t tq[$];
    min_t  mq[$];
    vec_t  tbl[5];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int exp_cnt = 0;

    logic [7:0] dpipe[LAT];
    logic [7:0] d;

    function automatic logic [7:0] min3(input logic [7:0] x, input logic [7:0] y,
                                        input logic [7:0] z);
        logic [7:0] m;
        m = (x < y) ? x : y;
        return (m < z) ? m : z;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Model of the downstream min stage: LAT registered stages after a/b/c.
    always @(posedge clk) begin
        dpipe[0] <= min3(a, b, c);
        for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
    end
    assign d = dpipe[LAT-1];

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (min_valid) begin
                if (mq.size() == 0) begin
                    check("min_valid_unexpected", 1, 0);
                end else begin
                    min_t e;
                    e = mq.pop_front();
                    check("min_valid_timing", cyc, e.due);
                    check("d_value", d, e.m);
                end
            end
            if (mq.size() > 0 && mq[0].due < cyc) begin
                min_t e;
                e = mq.pop_front();
                check("min_valid_missing", 0, 1);
            end
            if (trip_valid) begin
                if (tq.size() == 0) begin
                    check("trip_valid_unexpected", 1, 0);
                end else begin
                    trip_t t;
                    t = tq.pop_front();
                    check("a", a, t.a);
                    check("b", b, t.b);
                    check("c", c, t.c);
                    mq.push_back('{m: min3(t.a, t.b, t.c), due: cyc + LAT});
                end
            end
        end
    end

    task automatic send(input logic [7:0] v);
        in_valid = 1'b1;
        in_data  = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_triple(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
        tq.push_back('{a: x, b: y, c: z});
        exp_cnt++;
        send(x);
        send(y);
        send(z);
    endtask

    task automatic flush_cycle();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (tq.size() == 0 && mq.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drain_trip_q", tq.size(), 0);
        check("drain_min_q", mq.size(), 0);
    endtask

    initial begin
        tbl[0] = '{x: 8'd200, y: 8'd100, z: 8'd150, m: 8'd100};
        tbl[1] = '{x: 8'd0,   y: 8'd255, z: 8'd7,   m: 8'd0};
        tbl[2] = '{x: 8'd255, y: 8'd255, z: 8'd255, m: 8'd255};
        tbl[3] = '{x: 8'd9,   y: 8'd9,   z: 8'd1,   m: 8'd1};
        tbl[4] = '{x: 8'd1,   y: 8'd2,   z: 8'd3,   m: 8'd1};

        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'd0;
        flush    = 1'b0;

        // 1. Asynchronous reset mid-cycle
        #7 rst_n = 1'b0;
        #1;
        check("rst_a", a, 0);
        check("rst_b", b, 0);
        check("rst_c", c, 0);
        check("rst_trip_valid", trip_valid, 0);
        check("rst_min_valid", min_valid, 0);
        check("rst_fill", fill, 0);
        check("rst_trip_cnt", trip_cnt, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_fill", fill, 0);

        // 2. Back-to-back triple, min 3
        send_triple(8'd5, 8'd3, 8'd9);
        check("t2_trip_valid", trip_valid, 1);
        check("t2_trip_cnt", trip_cnt, exp_cnt);
        check("sat_cnt", s_trip_cnt, (exp_cnt > 3) ? 3 : exp_cnt);

        // Table of back-to-back triples; saturating counter tracked throughout
        for (int i = 0; i < 5; i++) begin
            check("tbl_min_model", min3(tbl[i].x, tbl[i].y, tbl[i].z), tbl[i].m);
            send_triple(tbl[i].x, tbl[i].y, tbl[i].z);
            check("tbl_trip_cnt", trip_cnt, exp_cnt);
            check("sat_cnt", s_trip_cnt, (exp_cnt > 3) ? 3 : exp_cnt);
        end
        drain();

        // 3. Gapped stream: 10, idle, 20, idle, idle, 7
        send(8'd10);
        check("gap_fill1", fill, 1);
        idle(1);
        check("gap_fill1_hold", fill, 1);
        send(8'd20);
        check("gap_fill2", fill, 2);
        idle(2);
        check("gap_fill2_hold", fill, 2);
        check("gap_a_held", a, 8'd1);
        check("gap_b_held", b, 8'd2);
        check("gap_c_held", c, 8'd3);
        tq.push_back('{a: 8'd10, b: 8'd20, c: 8'd7});
        exp_cnt++;
        send(8'd7);
        check("gap_fill0", fill, 0);
        check("gap_trip_cnt", trip_cnt, exp_cnt);
        drain();

        // 4. Flush with a partial triple in S2, concurrent valid byte
        send(8'd4);
        send(8'd1);
        check("fl_fill2", fill, 2);
`ifdef MIN3_LOADER_PAD_EN
        tq.push_back('{a: 8'd4, b: 8'd1, c: 8'hFF});
        exp_cnt++;
`endif
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd8;
        #1;
        check("fl_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_fill0", fill, 0);
        check("fl_trip_cnt", trip_cnt, exp_cnt);
`ifndef MIN3_LOADER_PAD_EN
        check("fl_a_held", a, 8'd10);
        check("fl_c_held", c, 8'd7);
`endif
        drain();

        // Flush in S1
        send(8'd6);
        check("fl1_fill1", fill, 1);
`ifdef MIN3_LOADER_PAD_EN
        tq.push_back('{a: 8'd6, b: 8'hFF, c: 8'hFF});
        exp_cnt++;
`endif
        flush_cycle();
        check("fl1_fill0", fill, 0);
        check("fl1_trip_cnt", trip_cnt, exp_cnt);
        drain();

        // Flush in S0 has no effect
        flush_cycle();
        check("fl0_fill", fill, 0);
        check("fl0_trip_cnt", trip_cnt, exp_cnt);

        // Alignment after flushes
        send_triple(8'd30, 8'd40, 8'd50);
        check("post_fl_trip_cnt", trip_cnt, exp_cnt);
        drain();

        // 6. Reset one cycle after trip_valid, with fill=1 from the next triple
        send_triple(8'd11, 8'd22, 8'd33);
        send(8'd44);
        check("r6_fill1", fill, 1);
        #2 rst_n = 1'b0;
        tq.delete();
        mq.delete();
        exp_cnt = 0;
        #1;
        check("r6_fill", fill, 0);
        check("r6_a", a, 0);
        check("r6_b", b, 0);
        check("r6_c", c, 0);
        check("r6_min_valid", min_valid, 0);
        check("r6_trip_cnt", trip_cnt, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("r6_fill_rel", fill, 0);
        idle(3);
        send_triple(8'd12, 8'd13, 8'd14);
        check("r6_new_trip", trip_valid, 1);
        check("r6_new_cnt", trip_cnt, exp_cnt);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
